// File: rtl/svm_dma_pkg.sv
// Shared definitions for the SVM ROM read DMA.
//   dma_state_e : batch sequencing states
//   WORD_BYTES  : bytes per ROM word, used for the byte-to-word round-up
package svm_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/svm_dma_skid_fifo.sv
// Small circular skid buffer that absorbs ROM read data returning while the
// downstream FIFO is full.
//   clk, rst_n : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write strobe and word
//   pop, dout  : read strobe and combinational head word
//   count      : current occupancy
//   empty      : occupancy is zero
module svm_dma_skid_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/svm_rom_dma.sv
// Read DMA feeding the SVM core's ROM data FIFO from a fixed-latency ROM.
//   clk, rst_n                        : clock, asynchronous active-high reset
//   start_rd, cfg_ready               : batch request handshake (IDLE only)
//   cfg_dma_base_addr/num_bytes       : byte base address and byte length
//   batch_dma_done, dma_busy          : completion pulse and busy status
//   rom_rd_en, rom_addr, rom_rd_data  : synchronous ROM read port
//   rom_data_fifo_fifo_data_in/push   : word and push strobe to the core FIFO
//   rom_data_fifo_fifo_full           : core FIFO backpressure
module svm_rom_dma
  import svm_dma_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 16,
  parameter int ROM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_rd,
  input  logic                      cfg_ready,
  input  logic [ROM_ADDR_WIDTH-1:0] cfg_dma_base_addr,
  input  logic [ROM_ADDR_WIDTH-1:0] cfg_dma_num_bytes,
  output logic                      batch_dma_done,
  output logic                      dma_busy,
  output logic                      rom_rd_en,
  output logic [ROM_ADDR_WIDTH-3:0] rom_addr,
  input  logic [31:0]               rom_rd_data,
  output logic [31:0]               rom_data_fifo_fifo_data_in,
  output logic                      rom_data_fifo_fifo_data_push,
  input  logic                      rom_data_fifo_fifo_full
);

  localparam int AW    = ROM_ADDR_WIDTH;
  localparam int WA    = AW - 2;
  localparam int WL    = AW - 1;
  localparam int DEPTH = ROM_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  dma_state_e             state_q, state_d;
  logic [WA-1:0]          addr_q, addr_d;
  logic [WL-1:0]          words_left_q, words_left_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [ROM_LATENCY-1:0] vld_pipe_q, vld_pipe_d;

  logic          accept, rd_en, skid_wr, skid_pop, skid_empty;
  logic [CW-1:0] skid_count, skid_count_nxt;
  logic [CW:0]   occupancy;
  logic [31:0]   skid_dout;
  logic [AW:0]   bytes_rnd;
  logic [WL-1:0] words_req;
  logic          unused_bits;

  // One extra bit so the round-up cannot overflow at the maximum byte count.
  assign bytes_rnd   = {1'b0, cfg_dma_num_bytes} + (AW + 1)'(WORD_BYTES - 1);
  assign words_req   = bytes_rnd[AW:2];
  assign unused_bits = ^{bytes_rnd[1:0], cfg_dma_base_addr[1:0]};

  assign accept   = (state_q == IDLE) && start_rd && cfg_ready;
  assign skid_wr  = vld_pipe_q[ROM_LATENCY-1];
  assign skid_pop = !skid_empty && !rom_data_fifo_fifo_full;

  // Words already committed (in flight or buffered), less the one leaving
  // this cycle. Crediting the pop keeps one word/cycle streaming while still
  // bounding total storage to ROM_LATENCY+1 when the FIFO stalls.
  assign occupancy      = (CW + 1)'(inflight_q) + (CW + 1)'(skid_count) - (CW + 1)'(skid_pop);
  assign skid_count_nxt = skid_count + CW'(skid_wr) - CW'(skid_pop);

  svm_dma_skid_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (skid_wr),
    .pop   (skid_pop),
    .din   (rom_rd_data),
    .dout  (skid_dout),
    .count (skid_count),
    .empty (skid_empty)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      inflight_q   <= '0;
      vld_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      vld_pipe_q   <= vld_pipe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    inflight_d   = inflight_q + CW'(rd_en) - CW'(skid_wr);
    vld_pipe_d   = (vld_pipe_q << 1) | ROM_LATENCY'(rd_en);
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d       = cfg_dma_base_addr[AW-1:2];
          words_left_d = words_req;
          state_d      = (words_req == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_en) begin
          addr_d       = addr_q + 1'b1;
          words_left_d = words_left_q - 1'b1;
        end
        if (words_left_d == '0) state_d = DRAIN;
      end
      // Looks at next-cycle occupancy so done follows the last push directly.
      DRAIN: begin
        if (inflight_d == '0 && skid_count_nxt == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == RUN) && (words_left_q != '0) && (occupancy < (CW + 1)'(DEPTH));
  end

  assign rom_rd_en                    = rd_en;
  assign rom_addr                     = addr_q;
  assign batch_dma_done               = (state_q == DONE);
  assign dma_busy                     = (state_q != IDLE);
  assign rom_data_fifo_fifo_data_push = skid_pop;
  assign rom_data_fifo_fifo_data_in   = skid_pop ? skid_dout : 32'h0;

endmodule

// File: tb/tb_svm_rom_dma.sv
module tb_svm_rom_dma;

  logic        clk;
  logic        rst_n;
  logic        start_rd;
  logic        cfg_ready;
  logic [15:0] cfg_base;
  logic [15:0] cfg_num;
  logic        batch_dma_done;
  logic        dma_busy;
  logic        rom_rd_en;
  logic [13:0] rom_addr;
  logic [31:0] rom_rd_data;
  logic [31:0] fifo_data_in;
  logic        fifo_push;
  logic        fifo_full;

  svm_rom_dma #(
    .ROM_ADDR_WIDTH (16),
    .ROM_LATENCY    (1)
  ) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .start_rd                     (start_rd),
    .cfg_ready                    (cfg_ready),
    .cfg_dma_base_addr            (cfg_base),
    .cfg_dma_num_bytes            (cfg_num),
    .batch_dma_done               (batch_dma_done),
    .dma_busy                     (dma_busy),
    .rom_rd_en                    (rom_rd_en),
    .rom_addr                     (rom_addr),
    .rom_rd_data                  (rom_rd_data),
    .rom_data_fifo_fifo_data_in   (fifo_data_in),
    .rom_data_fifo_fifo_data_push (fifo_push),
    .rom_data_fifo_fifo_full      (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word i holds value i, one cycle of read latency.
  always @(posedge clk) begin
    if (rom_rd_en) rom_rd_data <= {18'b0, rom_addr};
  end

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic [31:0] rd_addr_q[$], rd_cyc_q[$], push_data_q[$], push_cyc_q[$];
  logic [31:0] done_cyc_q[$], done_busy_q[$];
  int          pwf = 0;

  always @(negedge clk) begin
    if (rom_rd_en) begin
      rd_addr_q.push_back(32'(rom_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (fifo_push) begin
      push_data_q.push_back(fifo_data_in);
      push_cyc_q.push_back(cyc);
      if (fifo_full) pwf++;
    end
    if (batch_dma_done) begin
      done_cyc_q.push_back(cyc);
      done_busy_q.push_back(32'(dma_busy));
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          rb, pb, db, fb, out_now, max_out;
  logic [31:0] t, r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic mark();
    rb = rd_addr_q.size();
    pb = push_data_q.size();
    db = done_cyc_q.size();
    fb = pwf;
  endtask

  task automatic start_batch(input logic [15:0] base, input logic [15:0] nbytes,
                             output logic [31:0] t_acc);
    @(posedge clk); #1;
    cfg_base  = base;
    cfg_num   = nbytes;
    start_rd  = 1'b1;
    cfg_ready = 1'b1;
    t_acc     = cyc;
    @(posedge clk); #1;
    start_rd  = 1'b0;
    cfg_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cyc_q.size() <= db && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 32'(done_cyc_q.size() > db), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    start_rd  = 1'b0;
    cfg_ready = 1'b0;
    cfg_base  = '0;
    cfg_num   = '0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(dma_busy), 0);
    check("rst_done",   32'(batch_dma_done), 0);
    check("rst_rd_en",  32'(rom_rd_en), 0);
    check("rst_push",   32'(fifo_push), 0);
    check("rst_addr",   32'(rom_addr), 0);
    check("rst_data",   fifo_data_in, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(dma_busy), 0);

    // 16 bytes from byte 0x10: words 4..7 stream back-to-back.
    mark();
    start_batch(16'h0010, 16'd16, t);
    wait_done("t1_done_seen");
    check("t1_rd_count", 32'(rd_addr_q.size() - rb), 4);
    check("t1_rd_first_cyc", qat(rd_cyc_q, rb), t + 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_rd_addr",   qat(rd_addr_q, rb + i),   32'(4 + i));
      check("t1_push_data", qat(push_data_q, pb + i), 32'(4 + i));
      check("t1_push_cyc",  qat(push_cyc_q, pb + i),  t + 3 + 32'(i));
    end
    check("t1_done_cyc", qat(done_cyc_q, db), t + 7);
    check("t1_busy_at_done", qat(done_busy_q, db), 1);
    @(posedge clk); #1;
    check("t1_busy_after", 32'(dma_busy), 0);
    check("t1_done_pulse_len", 32'(batch_dma_done), 0);

    // Zero-length batch completes at T+1 with no traffic.
    mark();
    start_batch(16'h0040, 16'd0, t);
    wait_done("t2_done_seen");
    check("t2_done_cyc", qat(done_cyc_q, db), t + 1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_rd_count",   32'(rd_addr_q.size() - rb), 0);
    check("t2_push_count", 32'(push_data_q.size() - pb), 0);

    // 5 bytes rounds up to 2 words; low base bits are ignored.
    mark();
    start_batch(16'h0013, 16'd5, t);
    wait_done("t3_done_seen");
    check("t3_rd_count",   32'(rd_addr_q.size() - rb), 2);
    check("t3_rd_addr0",   qat(rd_addr_q, rb), 4);
    check("t3_rd_addr1",   qat(rd_addr_q, rb + 1), 5);
    check("t3_push_count", 32'(push_data_q.size() - pb), 2);
    check("t3_push_data0", qat(push_data_q, pb), 4);
    check("t3_push_data1", qat(push_data_q, pb + 1), 5);

    // 8 words with the FIFO full for 10 cycles after the first push.
    mark();
    max_out = 0;
    start_batch(16'h0000, 16'd32, t);
    for (int n = 0; n < 50 && push_data_q.size() <= pb; n++) begin
      @(negedge clk); #1;
    end
    check("t4_first_push_seen", 32'(push_data_q.size() > pb), 1);
    @(posedge clk); #1;
    fifo_full = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      out_now = (rd_addr_q.size() - rb) - (push_data_q.size() - pb);
      if (out_now > max_out) max_out = out_now;
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    r = cyc;
    wait_done("t4_done_seen");
    check("t4_push_while_full", 32'(pwf - fb), 0);
    check("t4_max_buffered",    32'(max_out), 2);
    check("t4_resume_cyc",      qat(push_cyc_q, pb + 1), r);
    check("t4_rd_count",        32'(rd_addr_q.size() - rb), 8);
    check("t4_push_count",      32'(push_data_q.size() - pb), 8);
    for (int i = 0; i < 8; i++) begin
      check("t4_push_data", qat(push_data_q, pb + i), 32'(i));
    end

    // Word address wraps from 0x3FFF to 0x0000.
    mark();
    start_batch(16'hFFF8, 16'd16, t);
    wait_done("t5_done_seen");
    check("t5_rd_addr0", qat(rd_addr_q, rb),     32'h3FFE);
    check("t5_rd_addr1", qat(rd_addr_q, rb + 1), 32'h3FFF);
    check("t5_rd_addr2", qat(rd_addr_q, rb + 2), 32'h0000);
    check("t5_rd_addr3", qat(rd_addr_q, rb + 3), 32'h0001);
    check("t5_push_data0", qat(push_data_q, pb),     32'h3FFE);
    check("t5_push_data3", qat(push_data_q, pb + 3), 32'h0001);

    // Asynchronous reset in the middle of an 8-word batch.
    start_batch(16'h0000, 16'd32, t);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("t6_rst_busy",  32'(dma_busy), 0);
    check("t6_rst_rd_en", 32'(rom_rd_en), 0);
    check("t6_rst_push",  32'(fifo_push), 0);
    check("t6_rst_data",  fifo_data_in, 0);
    mark();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_rd_after_rst",   32'(rd_addr_q.size() - rb), 0);
    check("t6_no_push_after_rst", 32'(push_data_q.size() - pb), 0);
    check("t6_no_done_after_rst", 32'(done_cyc_q.size() - db), 0);

    // New batch completes; a second request while busy is ignored.
    mark();
    start_batch(16'h0020, 16'd8, t);
    @(posedge clk); #1;
    cfg_base  = 16'h0100;
    cfg_num   = 16'd40;
    start_rd  = 1'b1;
    cfg_ready = 1'b1;
    @(posedge clk); #1;
    start_rd  = 1'b0;
    cfg_ready = 1'b0;
    wait_done("t7_done_seen");
    check("t7_done_cyc",   qat(done_cyc_q, db), t + 5);
    check("t7_push_data0", qat(push_data_q, pb),     8);
    check("t7_push_data1", qat(push_data_q, pb + 1), 9);
    repeat (4) @(posedge clk);
    #1;
    check("t7_rd_count",   32'(rd_addr_q.size() - rb), 2);
    check("t7_push_count", 32'(push_data_q.size() - pb), 2);
    check("t7_done_count", 32'(done_cyc_q.size() - db), 1);
    check("t7_idle_busy",  32'(dma_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/svm_rom_dma.md
# svm_rom_dma

Read DMA engine that sits directly upstream of the SVM core. It accepts a batch request from the core's memory manager as a base address and a byte count. It streams the addressed 32-bit words out of a fixed-latency synchronous ROM into the core's ROM data FIFO, honouring FIFO backpressure. When the last word has been pushed, it returns a one-cycle batch-done pulse.

## Interface
Parameters:
- ROM_ADDR_WIDTH, 16: byte-address and byte-count width; matches the core's DMA config interface.
- ROM_LATENCY, 1: cycles from `rom_rd_en` to valid `rom_rd_data`; legal range 1..4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-high reset; the port name follows the codebase but the polarity is high.
- start_rd  in  1  batch request, level or pulse; sampled only in IDLE.
- cfg_ready  in  1  base address and byte count are valid; a request is accepted only when `start_rd` and `cfg_ready` are both high.
- cfg_dma_base_addr  in  ROM_ADDR_WIDTH  byte address; bits [1:0] are ignored, giving word alignment.
- cfg_dma_num_bytes  in  ROM_ADDR_WIDTH  batch length in bytes; word count = ceil(bytes/4).
- batch_dma_done  out  1  one-cycle pulse when the batch is complete.
- dma_busy  out  1  high from acceptance through the done pulse, inclusive.
- rom_rd_en  out  1  ROM read strobe.
- rom_addr  out  ROM_ADDR_WIDTH-2  ROM word address.
- rom_rd_data  in  32  ROM read data, valid ROM_LATENCY cycles after `rom_rd_en`.
- rom_data_fifo_fifo_data_in  out  32  word to the core FIFO.
- rom_data_fifo_fifo_data_push  out  1  push strobe to the core FIFO.
- rom_data_fifo_fifo_full  in  1  core FIFO full; no push occurs while it is high.

## Operation
- Reset values: all outputs 0; state IDLE; counters 0; skid buffer empty.
- States:
  - IDLE: waits for acceptance.
  - RUN: issues ROM reads.
  - DRAIN: all reads issued; waits for the in-flight reads and the skid buffer to empty.
  - DONE: drives `batch_dma_done` high for one cycle, then returns to IDLE.
- Acceptance:
  - Latch word address = base[ROM_ADDR_WIDTH-1:2].
  - Latch words_left = (num_bytes+3)>>2, computed with one extra bit so there is no overflow at the maximum count.
  - If the word count is 0, go directly to DONE.
- Read issue:
  - In RUN, assert `rom_rd_en` when words_left>0 and (inflight + skid_count) < ROM_LATENCY+1. This credit rule guarantees that returning data never overflows the skid buffer.
  - On each issue: increment the address, decrement words_left, increment inflight.
  - The word address wraps modulo 2^(ROM_ADDR_WIDTH-2), with no error.
- Return path:
  - A ROM_LATENCY-deep shift register of valid bits marks returning data.
  - Returning data is written into the skid buffer and inflight is decremented.
- Push:
  - Assert `rom_data_fifo_fifo_data_push` when the skid buffer is non-empty and `rom_data_fifo_fifo_full` is low. The data is the head of the skid buffer, and the buffer is popped in the same cycle.
  - A skid write and a pop in the same cycle leave the count unchanged.
- Transitions:
  - RUN to DRAIN when words_left reaches 0.
  - DRAIN to DONE when inflight==0 and the skid buffer is empty.
- `start_rd` outside IDLE is ignored. Configuration inputs are not re-sampled mid-batch.
- Reset mid-batch aborts immediately: no push or read occurs after reset, no done pulse is produced, and in-flight ROM data is discarded.

## Timing
- Request accepted at cycle T.
- First `rom_rd_en` at T+1.
- First data at the skid buffer at T+1+ROM_LATENCY.
- First push at T+2+ROM_LATENCY; this is T+3 for ROM_LATENCY=1.
- Throughput is 1 word/cycle while the FIFO is not full.
- `batch_dma_done` rises the cycle after the last push. For a zero-length batch it is at T+1.
- `dma_busy` is high from T+1 through the done cycle. IDLE can accept a new request in the cycle after done.
- Under a persistent full, at most ROM_LATENCY+1 words are buffered and reads stall. Pushes resume in the first cycle that full is low.

## Structure
- Shared package `svm_dma_pkg`:
  - State enum `dma_state_e` (IDLE, RUN, DRAIN, DONE).
  - Constant WORD_BYTES=4.
- Sub-module `svm_dma_skid_fifo`:
  - Parameterised depth (ROM_LATENCY+1) and width 32.
  - Ports: push, pop, data in/out, count, empty.
  - Registered storage; combinational head output.

## Test plan
- Base 0x0010, 16 bytes, FIFO never full, ROM word i = i: reads at word addresses 4..7; pushes data 4,5,6,7 on consecutive cycles, the first at T+3; done one cycle after the last push.
- 0 bytes: no `rom_rd_en`, no push, done at T+1.
- 5 bytes: 2 words read and pushed. Base 0x0013: reads begin at word address 4 (low bits ignored).
- Full held high for 10 cycles after the first push, 8-word batch: no push while full; at most 2 words buffered; all 8 words delivered in order with no loss or duplication.
- Base word address 0x3FFE, 16 bytes, ROM_ADDR_WIDTH=16: reads at word addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- `rst_n` pulsed high mid-batch: outputs return to 0 asynchronously; no done pulse; a subsequent new request completes normally. A `start_rd` pulse while busy is ignored.
